// File: rtl/sampq_arb.sv
// Sample-queue arbiter: captures per-source sample pulses into hold registers and
// round-robin writes them into a shared sample queue, under a small register interface.
module sampq_arb #(
  parameter int NSRC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [32*NSRC-1:0]   src_sample,
  input  logic [NSRC-1:0]      src_avail,
  output logic                 sq_active,
  input  logic                 sq_full,
  output logic [31:0]          sq_dat,
  output logic                 sq_wr,
  input  logic                 wb_stb_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_we_i,
  input  logic [15:0]          wb_adr_i,
  input  logic [7:0]           wb_dat_i,
  output logic [7:0]           wb_dat_o,
  output logic                 wb_ack_o
);

  localparam int LW = (NSRC > 1) ? $clog2(NSRC) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            r_state, w_state_d;
  logic                  r_active;
  logic [NSRC-1:0]       r_mask, r_pending, r_ovf;
  logic [NSRC-1:0][31:0] r_hold;
  logic [LW-1:0]         r_last;
  logic [31:0]           r_sq_dat;
  logic                  r_sq_wr;

  logic                  w_cmd, w_start, w_clr_ovf, w_mask_ld, w_cap_en;
  logic [1:0]            w_adr;
  logic [NSRC-1:0]       w_avm, w_coll, w_load, w_grant, w_pend_d, w_ovf_d;
  logic [LW-1:0]         w_cand, w_gnt_idx;
  logic                  w_gnt_vld;
  logic [3:0]            w_pend4, w_ovf4, w_mask4;
  logic                  w_unused;

  assign w_cmd     = wb_cyc_i & wb_stb_i & wb_we_i;
  assign w_adr     = wb_adr_i[1:0];
  assign w_start   = w_cmd && (w_adr == 2'd0) && wb_dat_i[0] && (r_state == S_IDLE);
  assign w_clr_ovf = w_cmd && (w_adr == 2'd2);
  assign w_mask_ld = w_cmd && (w_adr == 2'd1) && (r_state == S_IDLE);
  assign w_cap_en  = (r_state != S_IDLE);
  assign w_avm     = src_avail & r_mask & {NSRC{w_cap_en}};

  // Round-robin search from last+1; the LW-bit wrap assumes NSRC is a power of two.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = r_last;
    w_cand    = r_last;
    if (!sq_full) begin
      for (int k = 1; k <= NSRC; k++) begin
        w_cand = r_last + LW'(k);
        if (!w_gnt_vld && r_pending[w_cand]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = w_cand;
        end
      end
    end
    w_grant = w_gnt_vld ? (NSRC'(1) << w_gnt_idx) : '0;
  end

  // A busy, ungranted hold slot drops the new sample and flags overflow instead.
  assign w_coll   = w_avm & r_pending & ~w_grant;
  assign w_load   = w_avm & ~w_coll;
  assign w_pend_d = w_start ? '0 : ((r_pending & ~w_grant) | w_load);
  assign w_ovf_d  = ((w_start || w_clr_ovf) ? '0 : r_ovf) | w_coll;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_d = S_RUN;
      S_RUN:   if (w_cmd && (w_adr == 2'd0) && !wb_dat_i[0]) w_state_d = S_DRAIN;
      S_DRAIN: if ((r_pending == '0) && (w_avm == '0)) w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_active  <= 1'b0;
      r_mask    <= '0;
      r_pending <= '0;
      r_ovf     <= '0;
      r_hold    <= '0;
      r_last    <= LW'(NSRC - 1);
      r_sq_dat  <= '0;
      r_sq_wr   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_active  <= (w_state_d == S_RUN);
      r_pending <= w_pend_d;
      r_ovf     <= w_ovf_d;
      r_sq_wr   <= w_gnt_vld;
      if (w_mask_ld) r_mask <= wb_dat_i[NSRC-1:0];
      for (int i = 0; i < NSRC; i++) begin
        if (w_load[i]) r_hold[i] <= src_sample[32*i +: 32];
      end
      if (w_gnt_vld) begin
        r_sq_dat <= r_hold[w_gnt_idx];
        r_last   <= w_gnt_idx;
      end
    end
  end

  assign w_pend4 = 4'(r_pending);
  assign w_ovf4  = 4'(r_ovf);
  assign w_mask4 = 4'(r_mask);

  always_comb begin
    wb_dat_o = 8'h00;
    case (w_adr)
      2'd0:    wb_dat_o = {2'b00, w_ovf4, r_state == S_DRAIN, r_state == S_RUN};
      2'd1:    wb_dat_o = {4'h0, w_mask4};
      2'd2:    wb_dat_o = {4'h0, w_pend4};
      default: wb_dat_o = 8'h00;
    endcase
  end

  assign sq_active = r_active;
  assign sq_dat    = r_sq_dat;
  assign sq_wr     = r_sq_wr;
  assign wb_ack_o  = 1'b1;
  assign w_unused  = ^{wb_adr_i[15:2], wb_dat_i[7:NSRC]};

endmodule

// File: tb/tb_sampq_arb.sv
// Bench for sampq_arb: register table vectors, scoreboard of expected queue writes,
// and hand sequences for idle-ignore, round-robin, overflow, drain and async reset.
module tb_sampq_arb;
  localparam int NSRC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [32*NSRC-1:0] src_sample;
  logic [NSRC-1:0]   src_avail;
  logic              sq_active, sq_full, sq_wr;
  logic [31:0]       sq_dat;
  logic              wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
  logic [15:0]       wb_adr_i;
  logic [7:0]        wb_dat_i, wb_dat_o;

  sampq_arb #(.NSRC(NSRC)) dut (
    .clk(clk), .rst(rst), .src_sample(src_sample), .src_avail(src_avail),
    .sq_active(sq_active), .sq_full(sq_full), .sq_dat(sq_dat), .sq_wr(sq_wr),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [31:0] dat; int ecyc;} exp_t;
  exp_t sb[$];
  exp_t m_e;

  typedef struct {
    logic c, s, w;
    logic [1:0] adr;
    logic [7:0] dat;
    logic [7:0] exp_rd;
    logic       exp_act;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every queue write must match the head of the scoreboard, data and (if known) cycle.
  always @(posedge clk) begin
    #1;
    if (sq_wr === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got sq_dat=%h at cycle %0d expected no write",
                 sq_dat, cyc);
      end else begin
        m_e = sb.pop_front();
        check("sq_dat", sq_dat, m_e.dat);
        if (m_e.ecyc >= 0) check("wr_cycle", cyc, m_e.ecyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] adr, input logic [7:0] dat);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = {14'd0, adr}; wb_dat_i = dat;
    tick();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] adr, input logic [7:0] exp);
    wb_adr_i = {14'd0, adr};
    #1;
    check(name, {24'd0, wb_dat_o}, {24'd0, exp});
  endtask

  task automatic pulse(input logic [NSRC-1:0] av, input logic [32*NSRC-1:0] smp);
    src_sample = smp;
    src_avail  = av;
    tick();
    src_avail  = '0;
  endtask

  task automatic push(input logic [31:0] d, input int ec);
    exp_t e;
    e.dat  = d;
    e.ecyc = ec;
    sb.push_back(e);
  endtask

  task automatic add(input logic c, input logic s, input logic w, input logic [1:0] adr,
                     input logic [7:0] dat, input logic [7:0] exp_rd, input logic exp_act);
    vec_t v;
    v.c = c; v.s = s; v.w = w; v.adr = adr; v.dat = dat;
    v.exp_rd = exp_rd; v.exp_act = exp_act;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sq_full = 1'b0; src_avail = '0; src_sample = '0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = '0; wb_dat_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sq_wr", {31'd0, sq_wr}, 32'd0);
    check("rst_sq_dat", sq_dat, 32'd0);
    check("rst_active", {31'd0, sq_active}, 32'd0);
    rd_chk("rst_reg0", 2'd0, 8'h00);
    rd_chk("rst_reg1", 2'd1, 8'h00);
    rd_chk("rst_reg2", 2'd2, 8'h00);
    tick();
    rst = 1'b0;
    tick();

    // Each row: bus cycle driven; read value and sq_active reflect state before the write.
    add(0, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    add(1, 1, 1, 2'd1, 8'h0A, 8'h00, 0);
    add(0, 0, 0, 2'd1, 8'h00, 8'h0A, 0);
    add(0, 0, 0, 2'd3, 8'h00, 8'h00, 0);
    add(1, 1, 1, 2'd0, 8'h01, 8'h00, 0);
    add(0, 0, 0, 2'd0, 8'h00, 8'h01, 1);
    add(1, 1, 1, 2'd1, 8'h05, 8'h0A, 1);
    add(0, 0, 0, 2'd1, 8'h00, 8'h0A, 1);
    add(1, 1, 1, 2'd0, 8'h01, 8'h01, 1);
    add(0, 0, 0, 2'd3, 8'h00, 8'h00, 1);
    add(1, 1, 1, 2'd0, 8'h00, 8'h01, 1);
    add(0, 0, 0, 2'd0, 8'h00, 8'h02, 0);
    add(0, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    add(1, 1, 1, 2'd0, 8'h00, 8'h00, 0);
    add(0, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    add(0, 1, 1, 2'd1, 8'h03, 8'h0A, 0);
    add(1, 0, 1, 2'd1, 8'h03, 8'h0A, 0);
    add(1, 1, 0, 2'd1, 8'h03, 8'h0A, 0);
    add(1, 1, 1, 2'd1, 8'h0F, 8'h0A, 0);
    add(0, 0, 0, 2'd1, 8'h00, 8'h0F, 0);
    foreach (tbl[i]) begin
      wb_cyc_i = tbl[i].c; wb_stb_i = tbl[i].s; wb_we_i = tbl[i].w;
      wb_adr_i = {14'd0, tbl[i].adr}; wb_dat_i = tbl[i].dat;
      #1;
      check($sformatf("tbl_rd[%0d]", i), {24'd0, wb_dat_o}, {24'd0, tbl[i].exp_rd});
      check($sformatf("tbl_act[%0d]", i), {31'd0, sq_active}, {31'd0, tbl[i].exp_act});
      check("ack", {31'd0, wb_ack_o}, 32'd1);
      tick();
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;

    // Idle ignore: mask F, sources pulse while IDLE.
    pulse(4'hF, {32'h33, 32'h22, 32'h11, 32'h00});
    rd_chk("idle_pending", 2'd2, 8'h00);
    repeat (4) tick();

    // Round-robin from reset priority, twice.
    bus_wr(2'd0, 8'h01);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) push(32'(i) + 32'(r * 16), cyc + 2 + i);
      pulse(4'hF, {32'(3 + r * 16), 32'(2 + r * 16), 32'(1 + r * 16), 32'(r * 16)});
      repeat (6) tick();
    end
    bus_wr(2'd0, 8'h00);
    repeat (2) tick();
    rd_chk("rr_idle", 2'd0, 8'h00);

    // Backpressure and overflow on source 1.
    bus_wr(2'd1, 8'h02);
    bus_wr(2'd0, 8'h01);
    sq_full = 1'b1;
    pulse(4'h2, {32'h0, 32'h0, 32'hA0A0_0001, 32'h0});
    tick();
    pulse(4'h2, {32'h0, 32'h0, 32'hB0B0_0002, 32'h0});
    rd_chk("ovf_reg0", 2'd0, 8'h09);
    rd_chk("ovf_pend", 2'd2, 8'h02);
    push(32'hA0A0_0001, cyc + 1);
    sq_full = 1'b0;
    repeat (3) tick();
    rd_chk("ovf_pend_clr", 2'd2, 8'h00);
    rd_chk("ovf_still", 2'd0, 8'h09);
    bus_wr(2'd2, 8'h00);
    rd_chk("ovf_cleared", 2'd0, 8'h01);
    bus_wr(2'd0, 8'h00);
    repeat (2) tick();

    // Drain with a pending source 3 held off by sq_full.
    bus_wr(2'd1, 8'h08);
    bus_wr(2'd0, 8'h01);
    sq_full = 1'b1;
    pulse(4'h8, {32'hC0C0_0003, 32'h0, 32'h0, 32'h0});
    rd_chk("drn_pend", 2'd2, 8'h08);
    bus_wr(2'd0, 8'h00);
    rd_chk("drn_state", 2'd0, 8'h02);
    check("drn_active", {31'd0, sq_active}, 32'd0);
    repeat (3) tick();
    rd_chk("drn_hold", 2'd0, 8'h02);
    push(32'hC0C0_0003, cyc + 1);
    sq_full = 1'b0;
    repeat (2) tick();
    rd_chk("drn_idle", 2'd0, 8'h00);

    // Single path latency, then back-to-back pulses granted as they arrive.
    bus_wr(2'd1, 8'h01);
    bus_wr(2'd0, 8'h01);
    push(32'hDEAD_BEEF, cyc + 2);
    pulse(4'h1, {96'd0, 32'hDEAD_BEEF});
    repeat (4) tick();
    push(32'h1234_5678, cyc + 2);
    push(32'h9ABC_DEF0, cyc + 3);
    pulse(4'h1, {96'd0, 32'h1234_5678});
    pulse(4'h1, {96'd0, 32'h9ABC_DEF0});
    repeat (4) tick();
    rd_chk("b2b_no_ovf", 2'd0, 8'h01);
    rd_chk("b2b_pend", 2'd2, 8'h00);
    bus_wr(2'd0, 8'h00);
    repeat (2) tick();

    // Asynchronous reset mid-run with pending 4'h5.
    bus_wr(2'd1, 8'h05);
    bus_wr(2'd0, 8'h01);
    sq_full = 1'b1;
    pulse(4'h5, {32'h0, 32'h2222_2222, 32'h0, 32'h1111_1111});
    rd_chk("ar_pend", 2'd2, 8'h05);
    #2;
    wb_adr_i = 16'd2;
    rst = 1'b1;
    #1;
    check("ar_pend_clr", {24'd0, wb_dat_o}, 32'd0);
    check("ar_sq_wr", {31'd0, sq_wr}, 32'd0);
    check("ar_active", {31'd0, sq_active}, 32'd0);
    wb_adr_i = 16'd0;
    #1;
    check("ar_state", {24'd0, wb_dat_o}, 32'd0);
    tick();
    rst = 1'b0;
    sq_full = 1'b0;
    repeat (6) tick();
    rd_chk("ar_mask", 2'd1, 8'h00);

    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sampq_arb.md
SAMPQ_ARB -- requirements
Module: sampq_arb

Interface
REQ-001 Parameter NSRC, default 4, number of sample sources; only 4 is required to be supported.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 src_sample  input  32*NSRC  per-source sample word; source i occupies bits [32*i+31:32*i].
REQ-005 src_avail  input  NSRC  per-source one-cycle pulse; src_sample of that source is valid in that cycle.
REQ-006 sq_active  output  1  run indication broadcast to all sources.
REQ-007 sq_full  input  1  sample queue cannot accept a write this cycle.
REQ-008 sq_dat  output  32  sample queue write data, registered.
REQ-009 sq_wr  output  1  sample queue write strobe, registered, one cycle per entry.
REQ-010 wb_stb_i, wb_cyc_i, wb_we_i  input  1 each  bus command qualifiers.
REQ-011 wb_adr_i  input  16  register address; only bits [1:0] decoded.
REQ-012 wb_dat_i  input  8  write data.
REQ-013 wb_dat_o  output  8  read data, combinational from wb_adr_i[1:0].
REQ-014 wb_ack_o  output  1  tied to 1.

Function
REQ-015 States: IDLE (sq_active=0), RUN (sq_active=1), DRAIN (sq_active=0); sq_active is a registered decode of state.
REQ-016 Command = wb_cyc_i & wb_stb_i & wb_we_i.
- Register 0 write, data bit0=1, in IDLE: go to RUN, clear all pending and overflow flags.
- Register 0 write, data bit0=1, in RUN or DRAIN: ignored.
REQ-017 Register 0 write, data bit0=0, in RUN: go to DRAIN; in IDLE or DRAIN: ignored.
REQ-018 DRAIN to IDLE when no pending flag is set and no masked src_avail is high in that cycle.
REQ-019 Register 1 write in IDLE: load mask[NSRC-1:0] from wb_dat_i; ignored in RUN or DRAIN.
REQ-020 Register 2 write, any data, any state: clear all overflow flags.
- A capture overflow in the same cycle wins; the flag stays set.
REQ-021 Reads:
- Register 0: {2'b0, overflow[3:0], state==DRAIN, state==RUN}.
- Register 1: {4'b0, mask}.
- Register 2: {4'b0, pending[3:0]}.
- Register 3: 0.
REQ-022 Capture:
- In RUN or DRAIN, src_avail[i] & mask[i] loads hold[i] = src_sample slice and sets pending[i] at the next edge.
- In IDLE, src_avail is ignored.
REQ-023 Collision: if pending[i] is set and not granted in the same cycle that src_avail[i] (masked) is high:
- the new sample is dropped;
- hold[i] is unchanged;
- overflow[i] becomes 1 (sticky).
REQ-024 If pending[i] is granted in the same cycle as a new src_avail[i], the new sample is loaded and pending[i] stays 1; no overflow.
REQ-025 Grant: when sq_full=0 and any pending is set, grant exactly one source.
- Selection is round-robin, searching from last+1 modulo NSRC.
- At the next edge: sq_dat = hold[grant], sq_wr = 1, pending[grant] cleared, last = grant.
REQ-026 When sq_full=1 or no pending is set: sq_wr=0 next cycle, sq_dat holds its value, and last is unchanged.
REQ-027 Latency: src_avail high in cycle N with no contention and sq_full=0 gives sq_wr high in cycle N+2. Throughput is one entry per cycle.
REQ-028 sq_dat is 32 bits, passed unmodified; no source tag is inserted.

Reset
REQ-029 On rst assertion, asynchronously:
- state=IDLE, sq_active=0, sq_wr=0, sq_dat=0;
- pending=0, overflow=0, mask=0, hold=0;
- last=NSRC-1, so source 0 has first priority.
REQ-030 rst asserted mid-RUN or mid-DRAIN discards all pending samples; no sq_wr is issued until a new start after release.

Verification
REQ-031 Idle ignore: mask=4'hF, IDLE, src_avail=4'hF -> pending=0, sq_wr never 1.
REQ-032 Single path: mask=4'h1, start, src_avail[0] pulse with 32'hDEADBEEF in cycle N -> sq_wr=1 in N+2 only, sq_dat=32'hDEADBEEF.
REQ-033 Round-robin: mask=4'hF, all four pulse in one cycle with values 0..3 -> four consecutive sq_wr cycles with sq_dat 0,1,2,3; repeat -> same order.
REQ-034 Backpressure/overflow: mask=4'h2, sq_full=1, two src_avail[1] pulses with A then B -> overflow reads 4'h2; on sq_full=0 exactly one write of A; register 2 write -> overflow=0.
REQ-035 Drain: RUN with pending[3] set and sq_full=1, write register 0 = 0 -> state DRAIN, sq_active=0; on sq_full=0, one write then IDLE; register 0 reads 8'h00.
REQ-036 Reset mid-run: pending=4'h5, assert rst -> sq_wr=0, pending=0, state IDLE immediately, without waiting for a clock edge.
